instr_encoder: RTL and testbench

Converts field-level instruction requests (opcode, rd, rs1, rs2, imm) into 16-bit instruction words for the decode path. Writes them sequentially into instruction memory during program load. It sits between the test/boot loader and imem, on the write side of the opcode decoder. It owns format selection, immediate range checking, the imem address counter and load-session control.

---
 rtl/isa_pkg.sv | 71 +++++++
 rtl/instr_pack.sv | 46 ++++
 rtl/instr_encoder.sv | 130 +++++++++++++
 tb/tb_instr_encoder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit instruction set: opcodes, formats,
// field positions, immediate ranges and the encoder session states.
package isa_pkg;

  localparam int unsigned OPC_W    = 4;
  localparam int unsigned REG_W    = 3;
  localparam int unsigned IMM_W    = 12;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned ERRCNT_W = 8;

  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned RS2_LSB = 3;
  localparam int unsigned IMM6_W  = 6;
  localparam int unsigned IMM9_W  = 9;

  localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h2;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h3;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'h4;
  localparam logic [OPC_W-1:0] OP_SLT  = 4'h5;
  localparam logic [OPC_W-1:0] OP_LUI  = 4'h6;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'h7;
  localparam logic [OPC_W-1:0] OP_ST   = 4'h8;
  localparam logic [OPC_W-1:0] OP_LD   = 4'h9;
  localparam logic [OPC_W-1:0] OP_SHI  = 4'hA;
  localparam logic [OPC_W-1:0] OP_BEQ  = 4'hB;
  localparam logic [OPC_W-1:0] OP_BNE  = 4'hC;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'hD;
  localparam logic [OPC_W-1:0] OP_RSV0 = 4'hE;
  localparam logic [OPC_W-1:0] OP_RSV1 = 4'hF;

  localparam logic signed [IMM_W-1:0] IMM6_MIN = -12'sd32;
  localparam logic signed [IMM_W-1:0] IMM6_MAX = 12'sd31;
  localparam logic signed [IMM_W-1:0] IMM9_MIN = -12'sd256;
  localparam logic signed [IMM_W-1:0] IMM9_MAX = 12'sd255;

  typedef enum logic [2:0] {FMT_R, FMT_U, FMT_I, FMT_J, FMT_RSV} fmt_e;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_FULL} enc_state_e;

  function automatic fmt_e op_fmt(input logic [OPC_W-1:0] op);
    fmt_e f;
    if (op <= OP_SLT)       f = FMT_R;
    else if (op == OP_LUI)  f = FMT_U;
    else if (op <= OP_BNE)  f = FMT_I;
    else if (op == OP_JMP)  f = FMT_J;
    else                    f = FMT_RSV;
    return f;
  endfunction

  // Store and compare ops put rs2 in the rd slot.
  function automatic logic rd_is_rs2(input logic [OPC_W-1:0] op);
    return (op == OP_ST) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  // ImmSrc select as seen by the control unit's immediate generator.
  function automatic logic [1:0] imm_src(input fmt_e f);
    logic [1:0] s;
    case (f)
      FMT_R:   s = 2'b11;
      FMT_I:   s = 2'b01;
      FMT_U:   s = 2'b10;
      default: s = 2'b00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: opcode + operand fields -> 16-bit word plus a
// legality flag (reserved opcode or out-of-range immediate clears it).
module instr_pack import isa_pkg::*; (
  input  logic [OPC_W-1:0]  opcode_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic [REG_W-1:0]  rs1_i,
  input  logic [REG_W-1:0]  rs2_i,
  input  logic [IMM_W-1:0]  imm_i,
  output logic [WORD_W-1:0] word_o,
  output logic              legal_o
);

  logic signed [IMM_W-1:0] imm_s;
  assign imm_s = $signed(imm_i);

  always_comb begin
    word_o                  = '0;
    legal_o                 = 1'b0;
    word_o[OP_LSB +: OPC_W] = opcode_i;
    unique case (op_fmt(opcode_i))
      FMT_R: begin
        word_o[RD_LSB  +: REG_W] = rd_i;
        word_o[RS1_LSB +: REG_W] = rs1_i;
        word_o[RS2_LSB +: REG_W] = rs2_i;
        legal_o                  = 1'b1;
      end
      FMT_U: begin
        word_o[RD_LSB +: REG_W]  = rd_i;
        word_o[0 +: IMM9_W]      = imm_i[IMM9_W-1:0];
        legal_o                  = (imm_s >= IMM9_MIN) && (imm_s <= IMM9_MAX);
      end
      FMT_I: begin
        word_o[RD_LSB  +: REG_W] = rd_is_rs2(opcode_i) ? rs2_i : rd_i;
        word_o[RS1_LSB +: REG_W] = rs1_i;
        word_o[0 +: IMM6_W]      = imm_i[IMM6_W-1:0];
        legal_o                  = (imm_s >= IMM6_MIN) && (imm_s <= IMM6_MAX);
      end
      FMT_J: begin
        word_o[0 +: IMM_W]       = imm_i;
        legal_o                  = 1'b1;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Load-session encoder: packs requests into imem words, drops illegal ones,
// and streams the words to sequential imem addresses through one output register.
module instr_encoder import isa_pkg::*; #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned XLEN_I = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPC_W-1:0]    in_opcode,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [REG_W-1:0]    in_rs1,
  input  logic [REG_W-1:0]    in_rs2,
  input  logic [IMM_W-1:0]    in_imm,
  input  logic                in_last,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN_I-1:0]   mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_count
);

  enc_state_e          state_q, state_d;
  logic                vld_q, vld_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN_I-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;

  logic [WORD_W-1:0]   pack_word;
  logic                pack_legal;
  logic                out_free;
  logic [ADDR_W-1:0]   slot_addr;

  instr_pack u_pack (
    .opcode_i (in_opcode),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .imm_i    (in_imm),
    .word_o   (pack_word),
    .legal_o  (pack_legal)
  );

  // addr_q tracks completed writes; a pending word always sits at addr_q.
  assign out_free  = !vld_q || mem_ready;
  assign slot_addr = vld_q ? ADDR_W'(addr_q + 1'b1) : addr_q;

  always_comb begin
    state_d  = state_q;
    vld_d    = vld_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    errcnt_d = errcnt_q;
    in_ready = 1'b0;
    done     = 1'b0;

    if (vld_q && mem_ready) begin
      vld_d  = 1'b0;
      addr_d = ADDR_W'(addr_q + 1'b1);
    end

    unique case (state_q)
      S_IDLE:  ;
      S_LOAD:  in_ready = out_free;
      S_FULL:  in_ready = 1'b1;
      S_DRAIN: begin
        if (out_free) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // start aborts anything in flight and takes priority over a request
    if (start) begin
      in_ready = 1'b0;
      done     = 1'b0;
      state_d  = S_LOAD;
      vld_d    = 1'b0;
      addr_d   = '0;
      err_d    = 1'b0;
      errcnt_d = '0;
    end else if (in_valid && in_ready) begin
      if (state_q == S_LOAD && pack_legal) begin
        vld_d   = 1'b1;
        wdata_d = XLEN_I'(pack_word);
        if (in_last)        state_d = S_DRAIN;
        else if (&slot_addr) state_d = S_FULL;
      end else begin
        err_d = 1'b1;
        if (errcnt_q != {ERRCNT_W{1'b1}}) errcnt_d = ERRCNT_W'(errcnt_q + 1'b1);
        if (in_last) state_d = S_DRAIN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vld_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      vld_q    <= vld_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign mem_valid = vld_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign err_count = errcnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-size instance plus a 4-word
// instance sharing the same stimulus for the capacity case.
module tb_instr_encoder;

  logic        clk, rst, start, in_valid, in_last, mem_ready;
  logic [3:0]  in_opcode;
  logic [2:0]  in_rd, in_rs1, in_rs2;
  logic [11:0] in_imm;

  logic        in_ready, mem_valid, busy, done, err;
  logic [7:0]  mem_addr, err_count;
  logic [15:0] mem_wdata;

  logic        s_in_ready, s_mem_valid, s_busy, s_done, s_err;
  logic [1:0]  s_mem_addr;
  logic [7:0]  s_err_count;
  logic [15:0] s_mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int s_done_cnt = 0;
  int base;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [31:0] s_log_addr[$];
  logic [31:0] s_log_data[$];

  instr_encoder #(.ADDR_W(8), .XLEN_I(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err(err), .err_count(err_count)
  );

  instr_encoder #(.ADDR_W(2), .XLEN_I(16)) u_small (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last), .mem_valid(s_mem_valid), .mem_ready(mem_ready),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .busy(s_busy), .done(s_done),
    .err(s_err), .err_count(s_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // imem write log and done-pulse counters
  always @(posedge clk) begin
    if (!rst) begin
      if (mem_valid && mem_ready) begin
        log_addr.push_back(32'(mem_addr));
        log_data.push_back(32'(mem_wdata));
      end
      if (s_mem_valid && mem_ready) begin
        s_log_addr.push_back(32'(s_mem_addr));
        s_log_data.push_back(32'(s_mem_wdata));
      end
      if (done)   done_cnt++;
      if (s_done) s_done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string tag, input int idx, input logic [31:0] ea, input logic [31:0] ed);
    logic [31:0] ga, gd;
    ga = (idx < log_addr.size()) ? log_addr[idx] : 32'hxxxx_xxxx;
    gd = (idx < log_data.size()) ? log_data[idx] : 32'hxxxx_xxxx;
    check({tag, "_addr"}, ga, ea);
    check({tag, "_data"}, gd, ed);
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [11:0] imm, input logic last);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
    in_last   = last;
  endtask

  // Present a request at a negedge and hold it until the DUT will take it.
  task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic [11:0] imm, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    drive(op, rd, rs1, rs2, imm, last);
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic bus_idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    #1;
    check("start_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    s_log_addr.delete();
    s_log_data.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b1;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);

    // single R-type word, last
    clear_logs(); base = done_cnt;
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    send(4'h0, 3'd1, 3'd2, 3'd3, 12'h000, 1'b1);
    bus_idle();
    #1;
    check("t1_mem_valid", 32'(mem_valid), 32'd1);
    check("t1_mem_addr",  32'(mem_addr),  32'd0);
    check("t1_mem_wdata", 32'(mem_wdata), 32'h0298);
    check("t1_done",      32'(done),      32'd1);
    wait_idle("t1");
    check("t1_nwrites", 32'(log_addr.size()), 32'd1);
    check("t1_done_cnt", 32'(done_cnt - base), 32'd1);
    check("t1_err", 32'(err), 32'd0);

    // I / U / J formats back to back at the range edges
    clear_logs(); base = done_cnt;
    pulse_start();
    send(4'h7, 3'd5, 3'd1, 3'd0, 12'hFFF, 1'b0);
    send(4'h6, 3'd2, 3'd0, 3'd0, 12'd255, 1'b0);
    send(4'hD, 3'd0, 3'd0, 3'd0, 12'h800, 1'b1);
    bus_idle();
    wait_idle("t2");
    check("t2_nwrites", 32'(log_addr.size()), 32'd3);
    check_log("t2_w0", 0, 32'd0, 32'h7A7F);
    check_log("t2_w1", 1, 32'd1, 32'h64FF);
    check_log("t2_w2", 2, 32'd2, 32'hD800);
    check("t2_done_cnt", 32'(done_cnt - base), 32'd1);
    check("t2_err", 32'(err), 32'd0);

    // out-of-range imm6 and reserved opcode are dropped
    clear_logs(); base = done_cnt;
    pulse_start();
    send(4'h7, 3'd1, 3'd1, 3'd0, 12'd32, 1'b0);
    send(4'hE, 3'd1, 3'd1, 3'd1, 12'd0, 1'b0);
    bus_idle();
    repeat (2) @(negedge clk);
    check("t3_err",       32'(err),       32'd1);
    check("t3_err_count", 32'(err_count), 32'd2);
    check("t3_nwrites",   32'(log_addr.size()), 32'd0);
    send(4'h0, 3'd1, 3'd1, 3'd1, 12'd0, 1'b1);
    bus_idle();
    wait_idle("t3");
    check("t3_nwrites2", 32'(log_addr.size()), 32'd1);
    check_log("t3_w0", 0, 32'd0, 32'h0248);
    check("t3_err_count2", 32'(err_count), 32'd2);

    // imem backpressure for 5 cycles with a request waiting
    clear_logs(); base = done_cnt;
    pulse_start();
    mem_ready = 1'b0;
    send(4'h1, 3'd1, 3'd0, 3'd0, 12'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(4'h1, 3'd2, 3'd0, 3'd0, 12'd0, 1'b0);
      #1;
      check("t4_in_ready",  32'(in_ready),  32'd0);
      check("t4_mem_addr",  32'(mem_addr),  32'd0);
      check("t4_mem_wdata", 32'(mem_wdata), 32'h1200);
    end
    in_valid  = 1'b0;
    mem_ready = 1'b1;
    send(4'h1, 3'd2, 3'd0, 3'd0, 12'd0, 1'b0);
    send(4'h1, 3'd3, 3'd0, 3'd0, 12'd0, 1'b1);
    bus_idle();
    wait_idle("t4");
    check("t4_nwrites", 32'(log_addr.size()), 32'd3);
    check_log("t4_w0", 0, 32'd0, 32'h1200);
    check_log("t4_w1", 1, 32'd1, 32'h1400);
    check_log("t4_w2", 2, 32'd2, 32'h1600);

    // capacity exhaustion on the 4-word instance
    clear_logs(); base = s_done_cnt;
    pulse_start();
    for (int i = 1; i <= 5; i++)
      send(4'h1, 3'(i), 3'd0, 3'd0, 12'd0, (i == 5));
    bus_idle();
    wait_idle("t5");
    check("t5_s_busy",      32'(s_busy),      32'd0);
    check("t5_s_nwrites",   32'(s_log_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ga, gd;
      ga = (i < s_log_addr.size()) ? s_log_addr[i] : 32'hxxxx_xxxx;
      gd = (i < s_log_data.size()) ? s_log_data[i] : 32'hxxxx_xxxx;
      check("t5_s_addr", ga, 32'(i));
      check("t5_s_data", gd, 32'h1000 | 32'((i + 1) << 9));
    end
    check("t5_s_err",       32'(s_err),       32'd1);
    check("t5_s_err_count", 32'(s_err_count), 32'd1);
    check("t5_s_done_cnt",  32'(s_done_cnt - base), 32'd1);

    // abort with a pending word; start beats a simultaneous request
    clear_logs(); base = done_cnt;
    pulse_start();
    send(4'hE, 3'd0, 3'd0, 3'd0, 12'd0, 1'b0);
    mem_ready = 1'b0;
    send(4'h1, 3'd7, 3'd0, 3'd0, 12'd0, 1'b0);
    @(negedge clk);
    drive(4'h2, 3'd1, 3'd1, 3'd1, 12'd0, 1'b1);
    start = 1'b1;
    #1;
    check("t6_start_wins",  32'(in_ready),  32'd0);
    check("t6_pending",     32'(mem_valid), 32'd1);
    check("t6_pre_errcnt",  32'(err_count), 32'd1);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b1;
    #1;
    check("t6_mem_valid", 32'(mem_valid), 32'd0);
    check("t6_mem_addr",  32'(mem_addr),  32'd0);
    check("t6_err",       32'(err),       32'd0);
    check("t6_err_count", 32'(err_count), 32'd0);
    check("t6_busy",      32'(busy),      32'd1);
    check("t6_no_done",   32'(done_cnt - base), 32'd0);
    send(4'h2, 3'd1, 3'd1, 3'd1, 12'd0, 1'b1);
    bus_idle();
    wait_idle("t6");
    check("t6_nwrites", 32'(log_addr.size()), 32'd1);
    check_log("t6_w0", 0, 32'd0, 32'h2248);
    check("t6_done_cnt", 32'(done_cnt - base), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
